// File: rtl/fifo_stream_drain.sv
// Purpose : drains a counter-based synchronous FIFO into a valid/ready stream framed into PKT_LEN-beat packets.
// Latency : a FIFO read issued in cycle N is captured at the end of N+1 and is visible on m_valid/m_data from N+2.
// Backpr. : a 3-entry credit-tracked buffer; reads stop once buffered + in-flight words reach 3, and m_ready never reaches fifo_rd_en.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    drain enable; gates new FIFO reads only
//   fifo_empty/fifo_data  FIFO status and read data (data valid the cycle after fifo_rd_en)
//   fifo_rd_en            FIFO read strobe
//   m_valid/m_ready       output stream handshake
//   m_data/m_last         head-of-buffer word and end-of-packet marker
//   xfer_cnt              count of completed beats, wraps at 2^CNT_WIDTH
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  // Beat counter needs at least one bit even when PKT_LEN is 1.
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic [BW-1:0]         beat_cnt;
  logic [CNT_WIDTH-1:0]  xfer_q;
  logic                  capture;
  logic                  pop;
  logic [2:0]            credit_used;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one possibly on its way from the FIFO.
  // Keeping this below 3 guarantees a free slot for every capture.
  assign credit_used = {1'b0, buf_cnt} + {2'b00, inflight};
  assign fifo_rd_en  = en && !fifo_empty && (credit_used < 3'd3);

  assign capture  = inflight;
  assign m_valid  = (buf_cnt != 2'd0);
  assign pop      = m_valid && m_ready;
  assign m_data   = buf_mem[rd_ptr];
  assign m_last   = m_valid && (beat_cnt == LAST_BEAT);
  assign xfer_cnt = xfer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      xfer_q   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (capture) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_next(rd_ptr);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
        xfer_q   <= xfer_q + CNT_WIDTH'(1);
      end
      // Capture and pop together leave the occupancy unchanged; the popped
      // word is always the older one because rd_ptr trails wr_ptr.
      case ({capture, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed once buf_cnt covers them.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_mem[wr_ptr] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;
  localparam int DW = 8;
  localparam int PL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] xfer_cnt;

  logic          en2 = 1'b1;
  logic          fifo_empty2 = 1'b1;
  logic [DW-1:0] fifo_data2 = '0;
  logic          fifo_rd_en2;
  logic          m_valid2;
  logic          m_ready2 = 1'b1;
  logic [DW-1:0] m_data2;
  logic          m_last2;
  logic [3:0]    xfer_cnt2;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo2_q[$];
  int rd_cnt = 0;
  int beats = 0;

  fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .xfer_cnt(xfer_cnt)
  );

  fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_rd_en(fifo_rd_en2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_last(m_last2), .xfer_cnt(xfer_cnt2)
  );

  always #5 clk = ~clk;

  // Source FIFO model: registered data_out and empty flag, one-cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (fifo_q.size() == 0) begin
          failures++;
          $display("FAIL read_from_empty: fifo_rd_en=1 with 0 words stored (required no read)");
        end else begin
          fifo_data <= fifo_q.pop_front();
        end
        rd_cnt++;
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_empty2 <= 1'b1;
    end else begin
      if (fifo_rd_en2) begin
        checks++;
        if (fifo2_q.size() == 0) begin
          failures++;
          $display("FAIL read_from_empty2: fifo_rd_en=1 with 0 words stored (required no read)");
        end else begin
          fifo_data2 <= fifo2_q.pop_front();
        end
      end
      fifo_empty2 <= (fifo2_q.size() == 0);
    end
  end

  // Stream scoreboard: word order, packet framing, beat counter, credit bound, hold-under-stall.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] exp_d;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (xfer_cnt !== CW'(beats)) begin
        failures++;
        $display("FAIL xfer_cnt: got %0d required %0d", xfer_cnt, CW'(beats));
      end
      checks++;
      if (rd_cnt - beats > 3) begin
        failures++;
        $display("FAIL credit: %0d words buffered or in flight, required <= 3", rd_cnt - beats);
      end
      if (prev_stall) begin
        checks++;
        if (m_data !== prev_data || m_last !== prev_last) begin
          failures++;
          $display("FAIL hold: data/last %h/%b changed under stall, required %h/%b",
                   m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word: got %h, required no beat", m_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (m_data !== exp_d) begin
            failures++;
            $display("FAIL order: got %h required %h", m_data, exp_d);
          end
        end
        checks++;
        if (m_last !== ((beats % PL) == PL - 1)) begin
          failures++;
          $display("FAIL framing: beat %0d m_last=%b required %b", beats, m_last, (beats % PL) == PL - 1);
        end
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_models();
    fifo_q.delete();
    exp_q.delete();
    fifo2_q.delete();
    rd_cnt = 0;
    beats = 0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_models();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drained(output int left);
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) step();
    repeat (2) step();
    left = exp_q.size();
  endtask

  task automatic test_reset();
    en = 1'b1;
    m_ready = 1'b1;
    repeat (2) step();
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_last} !== 3'b000 || xfer_cnt !== '0) begin
      failures++;
      $display("FAIL reset_hold: rd/valid/last=%b xfer=%0d required 000/0", {fifo_rd_en, m_valid, m_last}, xfer_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_last} !== 3'b000 || xfer_cnt !== '0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: rd/valid/last=%b xfer=%0d required 000/0", i, {fifo_rd_en, m_valid, m_last}, xfer_cnt);
      end
    end
  endtask

  task automatic test_stream();
    logic [11:0] rd_h, v_h, l_h;
    en = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
    repeat (2) step();
    en = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      rd_h[i] = fifo_rd_en;
      v_h[i]  = m_valid;
      l_h[i]  = m_last;
      step();
      #1;
    end
    checks++;
    if (rd_h !== 12'h0FF) begin
      failures++;
      $display("FAIL stream_rd_pattern: got %b required %b", rd_h, 12'h0FF);
    end
    checks++;
    if (v_h !== 12'h3FC) begin
      failures++;
      $display("FAIL stream_valid_pattern: got %b required %b", v_h, 12'h3FC);
    end
    checks++;
    if (l_h !== 12'h220) begin
      failures++;
      $display("FAIL stream_last_pattern: got %b required %b", l_h, 12'h220);
    end
    checks++;
    if (xfer_cnt !== 16'd8) begin
      failures++;
      $display("FAIL stream_xfer: got %0d required 8", xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    int left;
    do_reset();
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
    repeat (2) step();
    en = 1'b1;
    #1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(fifo_rd_en);
      step();
      #1;
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL bp_read_pulses: got %0d required 3", pulses);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      failures++;
      $display("FAIL bp_head: valid/data=%b/%h required 1/11", m_valid, m_data);
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_path: fifo_rd_en=%b required 0 while full", fifo_rd_en);
    end
    wait_drained(left);
    checks++;
    if (left != 0 || xfer_cnt !== 16'd8) begin
      failures++;
      $display("FAIL bp_drain: %0d words left, xfer=%0d required 0 left, 8", left, xfer_cnt);
    end
  endtask

  task automatic test_en_gap();
    int left;
    do_reset();
    en = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    repeat (2) step();
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    repeat (6) step();
    checks++;
    if (xfer_cnt !== 16'd2 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_gap_count: xfer=%0d valid=%b required 2/0", xfer_cnt, m_valid);
    end
    en = 1'b1;
    #1;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      if (m_valid && m_ready && beats == 2) begin
        checks++;
        if (m_data !== 8'hA2 || m_last !== 1'b0) begin
          failures++;
          $display("FAIL en_gap_third: data/last=%h/%b required a2/0", m_data, m_last);
        end
      end
      if (m_valid && m_ready && beats == 3) begin
        checks++;
        if (m_data !== 8'hA3 || m_last !== 1'b1) begin
          failures++;
          $display("FAIL en_gap_fourth: data/last=%h/%b required a3/1", m_data, m_last);
        end
      end
      step();
      #1;
    end
    checks++;
    if (beats < 4) begin
      failures++;
      $display("FAIL en_gap_timeout: %0d beats seen required 4", beats);
    end
    wait_drained(left);
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL en_gap_drain: %0d words left required 0", left);
    end
  endtask

  task automatic test_reset_mid();
    int left;
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    repeat (2) step();
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    repeat (2) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hC0) begin
      failures++;
      $display("FAIL mid_preload: valid/data=%b/%h required 1/c0", m_valid, m_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || xfer_cnt !== '0) begin
      failures++;
      $display("FAIL mid_async: valid/rd=%b/%b xfer=%0d required 0/0/0", m_valid, fifo_rd_en, xfer_cnt);
    end
    clear_models();
    repeat (2) step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
    en = 1'b1;
    #1;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      if (m_valid && m_ready && beats == 0) begin
        checks++;
        if (m_data !== 8'hD0 || m_last !== 1'b0 || xfer_cnt !== '0) begin
          failures++;
          $display("FAIL mid_first: data/last=%h/%b xfer=%0d required d0/0/0", m_data, m_last, xfer_cnt);
        end
      end
      if (m_valid && m_ready && beats == 3) begin
        checks++;
        if (m_last !== 1'b1) begin
          failures++;
          $display("FAIL mid_fourth_last: m_last=%b required 1", m_last);
        end
      end
      step();
      #1;
    end
    wait_drained(left);
    checks++;
    if (left != 0 || xfer_cnt !== 16'd5) begin
      failures++;
      $display("FAIL mid_drain: %0d left xfer=%0d required 0/5", left, xfer_cnt);
    end
  endtask

  task automatic test_random();
    int base;
    int n;
    int left;
    base = beats;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      en = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        push(8'($urandom_range(0, 255)));
        n++;
      end
    end
    wait_drained(left);
    checks++;
    if (left != 0 || xfer_cnt !== CW'(base + n)) begin
      failures++;
      $display("FAIL random_drain: %0d left xfer=%0d required 0/%0d", left, xfer_cnt, CW'(base + n));
    end
  endtask

  task automatic test_pkt1_wrap();
    logic [DW-1:0] w2 [17];
    int k;
    for (int i = 0; i < 17; i++) begin
      w2[i] = 8'(8'h40 + i);
      fifo2_q.push_back(w2[i]);
    end
    step();
    #1;
    k = 0;
    for (int c = 0; c < 80 && k < 17; c++) begin
      if (m_valid2 && m_ready2) begin
        checks++;
        if (m_data2 !== w2[k] || m_last2 !== 1'b1) begin
          failures++;
          $display("FAIL pkt1_beat[%0d]: data/last=%h/%b required %h/1", k, m_data2, m_last2, w2[k]);
        end
        k++;
        step();
        #1;
        checks++;
        if (xfer_cnt2 !== 4'(k)) begin
          failures++;
          $display("FAIL pkt1_xfer[%0d]: got %0d required %0d", k, xfer_cnt2, 4'(k));
        end
      end else begin
        step();
        #1;
      end
    end
    checks++;
    if (k != 17) begin
      failures++;
      $display("FAIL pkt1_timeout: %0d beats seen required 17", k);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_gap();
    test_reset_mid();
    test_random();
    test_pkt1_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at 400000 required finished");
    $fatal(1, "timeout");
  end

endmodule
